// File: rtl/sad_pkg.sv
// Shared definitions for the SAD minimum search: FSM encoding, default widths
// and the helper that narrows a SAD value to the display width.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sad_state_t;

    localparam int DEF_SAD_WIDTH = 16;
    localparam int DEF_NUM_WIDTH = 8;

    // Clamp to the largest value representable in numWidth bits.
    function automatic logic [31:0] satNarrow(input logic [31:0] value, input int numWidth);
        logic [31:0] limit;
        limit = (numWidth >= 32) ? 32'hFFFF_FFFF : ((32'd1 << numWidth) - 32'd1);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/sad_scan_counter.sv
// Raster-order row/column counter over a ROWS x COLS search window.
// It flags the final position so the consumer knows the window is complete.
module sad_scan_counter #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int NUM_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_advance,
    output logic [NUM_WIDTH-1:0] o_row,
    output logic [NUM_WIDTH-1:0] o_col,
    output logic                 o_last
);

    localparam logic [NUM_WIDTH-1:0] LAST_ROW = NUM_WIDTH'(ROWS - 1);
    localparam logic [NUM_WIDTH-1:0] LAST_COL = NUM_WIDTH'(COLS - 1);

    logic [NUM_WIDTH-1:0] r_row;
    logic [NUM_WIDTH-1:0] r_col;
    logic                 w_colWrap;
    logic                 w_rowWrap;

    assign w_colWrap = (r_col == LAST_COL);
    assign w_rowWrap = (r_row == LAST_ROW);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_colWrap) begin
                r_col <= '0;
                r_row <= w_rowWrap ? '0 : r_row + NUM_WIDTH'(1);
            end else begin
                r_col <= r_col + NUM_WIDTH'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_colWrap && w_rowWrap;

endmodule

// File: rtl/sad_min_search.sv
// Scans one window of SAD values, tracks the first strict minimum and its
// position, and publishes the result on registers that only change per window.
module sad_min_search
    import sad_pkg::*;
#(
    parameter int SAD_WIDTH = DEF_SAD_WIDTH,
    parameter int NUM_WIDTH = DEF_NUM_WIDTH,
    parameter int ROWS      = 4,
    parameter int COLS      = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic                 SadValid,
    input  logic [SAD_WIDTH-1:0] SadIn,
    output logic                 Busy,
    output logic                 Done,
    output logic [NUM_WIDTH-1:0] SADRow,
    output logic [NUM_WIDTH-1:0] SADColumn,
    output logic [NUM_WIDTH-1:0] MinSAD
);

    sad_state_t r_state;
    sad_state_t w_nextState;

    logic                 w_clear;
    logic                 w_advance;
    logic                 w_last;
    logic [NUM_WIDTH-1:0] w_row;
    logic [NUM_WIDTH-1:0] w_col;
    logic [NUM_WIDTH-1:0] w_minSat;

    logic                 r_busy;
    logic                 r_done;
    logic [NUM_WIDTH-1:0] r_outRow;
    logic [NUM_WIDTH-1:0] r_outCol;
    logic [NUM_WIDTH-1:0] r_outMin;
    logic [SAD_WIDTH-1:0] r_runMin;
    logic [NUM_WIDTH-1:0] r_minRow;
    logic [NUM_WIDTH-1:0] r_minCol;

    sad_scan_counter #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .NUM_WIDTH (NUM_WIDTH)
    ) u_counter (
        .i_clk     (Clk),
        .i_rst_n   (Rst_n),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_nextState = SCAN;
                    w_clear     = 1'b1;
                end
            end
            SCAN: begin
                if (SadValid) begin
                    w_advance = 1'b1;
                    if (w_last) w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign w_minSat = NUM_WIDTH'(satNarrow(32'(r_runMin), NUM_WIDTH));

    // Saturation happens only here; the running compare stays full width.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_outRow <= '0;
            r_outCol <= '0;
            r_outMin <= '0;
            r_runMin <= '0;
            r_minRow <= '0;
            r_minCol <= '0;
        end else begin
            r_busy <= (w_nextState != IDLE);
            r_done <= (r_state == DONE);
            if (r_state == IDLE && Start) begin
                r_runMin <= '1;
                r_minRow <= '0;
                r_minCol <= '0;
            end else if (r_state == SCAN && SadValid && (SadIn < r_runMin)) begin
                r_runMin <= SadIn;
                r_minRow <= w_row;
                r_minCol <= w_col;
            end
            if (r_state == DONE) begin
                r_outRow <= r_minRow;
                r_outCol <= r_minCol;
                r_outMin <= w_minSat;
            end
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign SADRow    = r_outRow;
    assign SADColumn = r_outCol;
    assign MinSAD    = r_outMin;

endmodule

// File: tb/tb_sad_min_search.sv
// Self-checking bench for sad_min_search: a window-level reference model
// checked every cycle, plus hand-computed results for the directed windows.
module tb_sad_min_search;

    localparam int NPOS = 16;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic        SadValid;
    logic [15:0] SadIn;
    logic        Busy;
    logic        Done;
    logic [7:0]  SADRow;
    logic [7:0]  SADColumn;
    logic [7:0]  MinSAD;

    int errors = 0;
    int checks = 0;
    int doneCount = 0;
    bit checkEnable = 1'b0;

    int winData[NPOS];

    // Reference model state, expressed in terms of windows of samples.
    int  winQ[$];
    bit  inWindow = 1'b0;
    bit  finishing = 1'b0;
    bit  expBusy = 1'b0;
    bit  expDone = 1'b0;
    int  expRow = 0;
    int  expCol = 0;
    int  expMin = 0;

    sad_min_search dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .SadValid  (SadValid),
        .SadIn     (SadIn),
        .Busy      (Busy),
        .Done      (Done),
        .SADRow    (SADRow),
        .SADColumn (SADColumn),
        .MinSAD    (MinSAD)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // First-in-raster-order minimum of a completed window.
    task automatic windowResult();
        int best;
        int bestIdx;
        best = winQ[0];
        bestIdx = 0;
        for (int i = 1; i < NPOS; i++) begin
            if (winQ[i] < best) begin
                best = winQ[i];
                bestIdx = i;
            end
        end
        expRow = bestIdx / 4;
        expCol = bestIdx % 4;
        expMin = (best > 255) ? 255 : best;
    endtask

    always @(posedge Clk) begin
        if (!Rst_n) begin
            expBusy = 0; expDone = 0;
            expRow = 0; expCol = 0; expMin = 0;
            inWindow = 0; finishing = 0;
            winQ.delete();
        end else begin
            expDone = 0;
            if (finishing) begin
                windowResult();
                expDone = 1;
                expBusy = 0;
                finishing = 0;
            end else if (inWindow) begin
                if (SadValid) winQ.push_back(int'(SadIn));
                if (winQ.size() == NPOS) begin
                    inWindow = 0;
                    finishing = 1;
                end
            end else if (Start) begin
                inWindow = 1;
                winQ.delete();
                expBusy = 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (checkEnable) begin
            checkOutput("busy", int'(Busy), int'(expBusy));
            checkOutput("done", int'(Done), int'(expDone));
            checkOutput("row", int'(SADRow), expRow);
            checkOutput("col", int'(SADColumn), expCol);
            checkOutput("min", int'(MinSAD), expMin);
            if (Done) doneCount++;
        end
    end

    task automatic applyStimulus(input logic start, input logic valid, input int sad);
        Start = start;
        SadValid = valid;
        SadIn = 16'(sad);
        @(negedge Clk);
    endtask

    task automatic fillWindow(input int background, input int idxA, input int valA,
                              input int idxB, input int valB);
        for (int i = 0; i < NPOS; i++) winData[i] = background;
        winData[idxA] = valA;
        winData[idxB] = valB;
    endtask

    // Start, stream the window with optional gaps, then cover the DONE cycle.
    task automatic sendWindow(input int gapCount, input bit startInScan, input bit startInDone);
        int gapsLeft;
        int doneBefore;
        gapsLeft = gapCount;
        doneBefore = doneCount;
        applyStimulus(1'b1, 1'b0, 0);
        for (int i = 0; i < NPOS; i++) begin
            if (i > 0 && gapsLeft > 0 && ($urandom_range(0, 1) == 0 || gapsLeft >= NPOS - i)) begin
                applyStimulus(startInScan, 1'b0, int'($urandom_range(0, 65535)));
                gapsLeft--;
            end
            applyStimulus(startInScan && (i == 4), 1'b1, winData[i]);
        end
        applyStimulus(startInDone, 1'b0, 0);
        checkOutput("doneLatency", int'(Done), 1);
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("donePulseEnd", int'(Done), 0);
        checkOutput("donePulses", doneCount - doneBefore, 1);
    endtask

    task automatic checkResult(input string name, input int row, input int col, input int minv);
        checkOutput({name, "Row"}, int'(SADRow), row);
        checkOutput({name, "Col"}, int'(SADColumn), col);
        checkOutput({name, "Min"}, int'(MinSAD), minv);
    endtask

    initial begin
        Rst_n = 1'b0;
        Start = 1'b1;
        SadValid = 1'b1;
        SadIn = 16'd123;
        @(negedge Clk);
        checkEnable = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("rstBusy", int'(Busy), 0);
        checkOutput("rstDone", int'(Done), 0);
        checkResult("rst", 0, 0, 0);

        // Samples while idle must not start a window.
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 7);
        checkOutput("idleBusy", int'(Busy), 0);

        fillWindow(500, 9, 37, 9, 37);
        sendWindow(0, 1'b0, 1'b0);
        checkResult("single", 2, 1, 37);

        fillWindow(90, 3, 20, 12, 20);
        sendWindow(0, 1'b0, 1'b0);
        checkResult("tie", 0, 3, 20);

        for (int i = 0; i < NPOS; i++) winData[i] = 300 + i;
        sendWindow(0, 1'b0, 1'b0);
        checkResult("sat", 0, 0, 255);

        fillWindow(500, 9, 37, 9, 37);
        sendWindow(5, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1);
        checkOutput("gapIdleBusy", int'(Busy), 0);
        checkResult("gap", 2, 1, 37);

        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < NPOS; i++) winData[i] = int'($urandom_range(0, 600));
            sendWindow(int'($urandom_range(0, 6)), w[0], w[1]);
            applyStimulus(1'b0, 1'b0, 0);
        end

        // A reset in the middle of a window discards it and clears the outputs.
        fillWindow(500, 9, 37, 9, 37);
        sendWindow(0, 1'b0, 1'b0);
        checkResult("first", 2, 1, 37);
        fillWindow(400, 0, 5, 0, 5);
        applyStimulus(1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, winData[i]);
        Rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 3);
        Rst_n = 1'b1;
        checkOutput("midRstBusy", int'(Busy), 0);
        checkResult("midRst", 0, 0, 0);
        fillWindow(200, 15, 1, 15, 1);
        sendWindow(0, 1'b0, 1'b0);
        checkResult("fresh", 3, 3, 1);

        applyStimulus(1'b0, 1'b0, 0);
        checkEnable = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
